// File: rtl/fib_inv_des.sv
// ============================================================================
// Module   : fib_inv_des
// Purpose  : Inverse Fibonacci. Converts a 4-digit BCD x to binary, then walks
//            the Fibonacci sequence to find the largest n with fib(n) <= x.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fib_inv_des (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iSTART,
    input  logic [3:0] iBCD3,
    input  logic [3:0] iBCD2,
    input  logic [3:0] iBCD1,
    input  logic [3:0] iBCD0,
    output logic       oREADY,
    output logic       oDONE,
    output logic       oEXACT,
    output logic       oERR,
    output logic [3:0] oBCD1,
    output logic [3:0] oBCD0
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_digits;
    logic [1:0]  r_cnt;
    logic [13:0] r_acc;
    logic [13:0] r_a;
    logic [14:0] r_b;
    logic [4:0]  r_n;
    logic        r_exact;
    logic        r_err;
    logic [3:0]  r_bcd1;
    logic [3:0]  r_bcd0;

    logic        w_bad;
    logic [3:0]  w_digit;
    logic [13:0] w_acc_next;
    logic        w_stop;
    logic [14:0] w_sum;
    logic [3:0]  w_tens;
    logic [3:0]  w_units;

    assign w_bad = (iBCD3 > 4'd9) || (iBCD2 > 4'd9) ||
                   (iBCD1 > 4'd9) || (iBCD0 > 4'd9);

    always_comb begin
        w_digit = 4'd0;
        case (r_cnt)
            2'd3: w_digit = r_digits[15:12];
            2'd2: w_digit = r_digits[11:8];
            2'd1: w_digit = r_digits[7:4];
            2'd0: w_digit = r_digits[3:0];
            default: w_digit = 4'd0;
        endcase
    end

    assign w_acc_next = r_acc * 14'd10 + {10'd0, w_digit};

    // Invariant in SEARCH: a = fib(n), b = fib(n+1); b never exceeds fib(21).
    assign w_stop = r_b > {1'b0, r_acc};
    assign w_sum  = {1'b0, r_a} + r_b;

    // n is at most 20; modulo-16 subtraction on the low nibble yields the units.
    always_comb begin
        w_tens  = 4'd0;
        w_units = r_n[3:0];
        if (r_n >= 5'd20) begin
            w_tens  = 4'd2;
            w_units = r_n[3:0] - 4'd4;
        end else if (r_n >= 5'd10) begin
            w_tens  = 4'd1;
            w_units = r_n[3:0] - 4'd10;
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iSTART) begin
                    w_next = w_bad ? S_DONE : S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == 2'd0) begin
                    w_next = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_stop) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_digits <= 16'd0;
            r_cnt    <= 2'd0;
            r_acc    <= 14'd0;
            r_a      <= 14'd0;
            r_b      <= 15'd0;
            r_n      <= 5'd0;
            r_exact  <= 1'b0;
            r_err    <= 1'b0;
            r_bcd1   <= 4'd0;
            r_bcd0   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iSTART) begin
                        r_digits <= {iBCD3, iBCD2, iBCD1, iBCD0};
                        r_exact  <= 1'b0;
                        r_err    <= w_bad;
                        r_bcd1   <= 4'd0;
                        r_bcd0   <= 4'd0;
                        r_acc    <= 14'd0;
                        r_cnt    <= 2'd3;
                    end
                end
                S_CONV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd0) begin
                        r_a <= 14'd0;
                        r_b <= 15'd1;
                        r_n <= 5'd0;
                    end
                end
                S_SEARCH: begin
                    if (w_stop) begin
                        r_exact <= (r_a == r_acc);
                        r_bcd1  <= w_tens;
                        r_bcd0  <= w_units;
                    end else begin
                        r_a <= r_b[13:0];
                        r_b <= w_sum;
                        r_n <= r_n + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oREADY = (r_state == S_IDLE);
    assign oDONE  = (r_state == S_DONE);
    assign oEXACT = r_exact;
    assign oERR   = r_err;
    assign oBCD1  = r_bcd1;
    assign oBCD0  = r_bcd0;

endmodule

`default_nettype wire

// File: tb/tb_fib_inv_des.sv
// ============================================================================
// Module   : tb_fib_inv_des
// Purpose  : Self-checking bench for fib_inv_des (directed table, random runs,
//            back-to-back, start noise and mid-search reset sequences).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fib_inv_des;

    logic       iCLK = 1'b0;
    logic       iRESET = 1'b1;
    logic       iSTART = 1'b0;
    logic [3:0] iBCD3 = 4'd0;
    logic [3:0] iBCD2 = 4'd0;
    logic [3:0] iBCD1 = 4'd0;
    logic [3:0] iBCD0 = 4'd0;
    logic       oREADY;
    logic       oDONE;
    logic       oEXACT;
    logic       oERR;
    logic [3:0] oBCD1;
    logic [3:0] oBCD0;

    int n_pass  = 0;
    int n_total = 0;

    fib_inv_des dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iSTART (iSTART),
        .iBCD3  (iBCD3),
        .iBCD2  (iBCD2),
        .iBCD1  (iBCD1),
        .iBCD0  (iBCD0),
        .oREADY (oREADY),
        .oDONE  (oDONE),
        .oEXACT (oEXACT),
        .oERR   (oERR),
        .oBCD1  (oBCD1),
        .oBCD0  (oBCD0)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [15:0] dg;
        int          n;
        bit          ex;
        bit          er;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: build the Fibonacci table and pick the largest index <= x.
    function automatic void model(input logic [15:0] dg, output int n,
                                  output bit ex, output bit er, output int lat);
        int f[22];
        int x;
        er = (dg[15:12] > 9) || (dg[11:8] > 9) || (dg[7:4] > 9) || (dg[3:0] > 9);
        n  = 0;
        ex = 1'b0;
        lat = 1;
        if (!er) begin
            x = int'(dg[15:12]) * 1000 + int'(dg[11:8]) * 100 +
                int'(dg[7:4]) * 10 + int'(dg[3:0]);
            f[0] = 0;
            f[1] = 1;
            for (int k = 2; k < 22; k++) f[k] = f[k-1] + f[k-2];
            for (int k = 0; k < 22; k++) if (f[k] <= x) n = k;
            ex  = (f[n] == x);
            lat = n + 6;
        end
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int c;
        c = 0;
        while (!oREADY && c < 40) begin
            tick();
            c++;
        end
        if (!oREADY) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    // Starts an operation from IDLE; returns the cycle index (edge 0 -> cycle 1)
    // at which oDONE is seen. With noisy set, iSTART and garbage digits are
    // driven during cycles 5..8.
    task automatic run_op(input logic [15:0] dg, input bit noisy,
                          output int lat, output bit to);
        {iBCD3, iBCD2, iBCD1, iBCD0} = dg;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        lat = 1;
        to  = 1'b0;
        while (!oDONE) begin
            if (noisy && lat >= 5 && lat <= 8) begin
                iSTART = 1'b1;
                {iBCD3, iBCD2, iBCD1, iBCD0} = 16'h0000;
            end else begin
                iSTART = 1'b0;
            end
            tick();
            lat++;
            if (lat > 40) begin
                to = 1'b1;
                break;
            end
        end
        iSTART = 1'b0;
    endtask

    task automatic check_op(input logic [15:0] dg, input int en, input bit eex,
                            input bit eer, input int elat, input bit noisy,
                            input string nm);
        int  lat;
        bit  to;
        logic [7:0] ebcd;
        ebcd = {4'(en / 10), 4'(en % 10)};
        wait_ready(nm);
        run_op(dg, noisy, lat, to);
        chk({nm, "_timeout"}, int'(to), 0);
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_bcd"}, int'({oBCD1, oBCD0}), int'(ebcd));
        chk({nm, "_exact"}, int'(oEXACT), int'(eex));
        chk({nm, "_err"}, int'(oERR), int'(eer));
        tick();
        chk({nm, "_done_width"}, int'(oDONE), 0);
        chk({nm, "_ready_after"}, int'(oREADY), 1);
        chk({nm, "_hold"}, int'({oERR, oEXACT, oBCD1, oBCD0}),
            int'({eer, eex, ebcd}));
    endtask

    initial begin
        int  en, elat, lat, d;
        bit  eex, eer, to;
        logic [15:0] dg;
        int  done_cyc[3];
        int  pulses, cyc, seen;

        tbl[0] = '{16'h0000,  0, 1'b1, 1'b0,  6, "x0000"};
        tbl[1] = '{16'h0001,  2, 1'b1, 1'b0,  8, "x0001"};
        tbl[2] = '{16'h0002,  3, 1'b1, 1'b0,  9, "x0002"};
        tbl[3] = '{16'h0004,  4, 1'b0, 1'b0, 10, "x0004"};
        tbl[4] = '{16'h0005,  5, 1'b1, 1'b0, 11, "x0005"};
        tbl[5] = '{16'h0100, 11, 1'b0, 1'b0, 17, "x0100"};
        tbl[6] = '{16'h0144, 12, 1'b1, 1'b0, 18, "x0144"};
        tbl[7] = '{16'h6765, 20, 1'b1, 1'b0, 26, "x6765"};
        tbl[8] = '{16'h9999, 20, 1'b0, 1'b0, 26, "x9999"};
        tbl[9] = '{16'h00A0,  0, 1'b0, 1'b1,  1, "x00A0"};

        #2;
        chk("rst_ready", int'(oREADY), 1);
        chk("rst_done", int'(oDONE), 0);
        chk("rst_outs", int'({oERR, oEXACT, oBCD1, oBCD0}), 0);
        tick();
        tick();
        iRESET = 1'b0;
        tick();

        foreach (tbl[i]) begin
            check_op(tbl[i].dg, tbl[i].n, tbl[i].ex, tbl[i].er, tbl[i].lat,
                     1'b0, tbl[i].name);
        end
        // A valid run straight after an error must be clean.
        check_op(16'h0013, 7, 1'b1, 1'b0, 13, 1'b0, "after_err");

        // Start requests with garbage digits during CONV/SEARCH must be ignored.
        check_op(16'h9999, 20, 1'b0, 1'b0, 26, 1'b1, "noisy9999");
        check_op(16'h0144, 12, 1'b1, 1'b0, 18, 1'b1, "noisy0144");

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 4; k++) begin
                d = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 15)
                                                 : $urandom_range(0, 9);
                dg[k*4 +: 4] = 4'(d);
            end
            if (r % 5 == 0) dg[15:12] = 4'($urandom_range(6, 9));
            model(dg, en, eex, eer, elat);
            check_op(dg, en, eex, eer, elat, (!eer && en >= 3 && r[0]),
                     $sformatf("rand%0d_%04h", r, dg));
        end

        // iSTART held high: repeated results with a single-cycle oDONE each.
        wait_ready("b2b");
        {iBCD3, iBCD2, iBCD1, iBCD0} = 16'h0144;
        iSTART = 1'b1;
        pulses = 0;
        cyc = 0;
        while (pulses < 3 && cyc < 100) begin
            tick();
            cyc++;
            if (oDONE) begin
                done_cyc[pulses] = cyc;
                chk($sformatf("b2b%0d_bcd", pulses), int'({oBCD1, oBCD0}), 8'h12);
                chk($sformatf("b2b%0d_exact", pulses), int'(oEXACT), 1);
                pulses++;
                tick();
                cyc++;
                chk($sformatf("b2b%0d_single", pulses), int'(oDONE), 0);
            end
        end
        iSTART = 1'b0;
        chk("b2b_pulses", pulses, 3);
        if (pulses == 3) begin
            chk("b2b_first_lat", done_cyc[0], 18);
            chk("b2b_gap1", done_cyc[1] - done_cyc[0], 19);
            chk("b2b_gap2", done_cyc[2] - done_cyc[1], 19);
        end

        // Reset during SEARCH aborts immediately and suppresses oDONE.
        check_op(16'h9999, 20, 1'b0, 1'b0, 26, 1'b0, "pre_abort");
        {iBCD3, iBCD2, iBCD1, iBCD0} = 16'h9999;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        iRESET = 1'b1;
        #1;
        chk("abort_ready", int'(oREADY), 1);
        chk("abort_done", int'(oDONE), 0);
        chk("abort_outs", int'({oERR, oEXACT, oBCD1, oBCD0}), 0);
        tick();
        iRESET = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (oDONE) seen++;
        end
        chk("abort_no_done", seen, 0);
        check_op(16'h9999, 20, 1'b0, 1'b0, 26, 1'b0, "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
